// File: rtl/cell_bist_ctrl.sv
// Built-in self-test controller for a single OAI22 cell: sweeps all 16 input
// patterns, checks each response against a golden model and compacts them in an 8-bit MISR.
module cell_bist_ctrl #(
   parameter logic [7:0] SIG_SEED = 8'hFF,
   parameter logic [7:0] EXP_SIG  = 8'h5E
) (
   input  logic       CLK,
   input  logic       RN,
   input  logic       START,
   input  logic       ABORT,
   input  logic       Y_IN,
   output logic       A1,
   output logic       A2,
   output logic       B1,
   output logic       B2,
   output logic       BUSY,
   output logic       DONE,
   output logic       PASS,
   output logic [4:0] FAIL_CNT,
   output logic [7:0] SIG
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      DONE_ST = 2'd2
   } state_t;

   state_t     state;
   state_t     state_next;
   logic [3:0] pat_cnt;
   logic       accept;
   logic       capture;
   logic       exp_y;
   logic [7:0] misr_next;

   // START is only honoured outside RUN; ABORT suppresses the capture at its edge.
   assign accept  = (state != RUN) && START;
   assign capture = (state == RUN) && !ABORT;

   // Golden response for the pattern currently held on the stimulus outputs.
   assign exp_y = ~((pat_cnt[3] | pat_cnt[2]) & (pat_cnt[1] | pat_cnt[0]));

   // MISR with polynomial x^8+x^4+x^3+x^2+1, response folded into bit 0.
   assign misr_next = {SIG[6:0], 1'b0} ^ (SIG[7] ? 8'h1D : 8'h00) ^ {7'b0, Y_IN};

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of process ordering.
   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) state <= IDLE;
      else     state <= state_next;
   end

   // NOTE: defaulting state_next first keeps this block free of inferred latches.
   always_comb begin
      state_next = state;
      case (state)
         IDLE, DONE_ST: if (START) state_next = RUN;
         RUN: begin
            if (ABORT)                state_next = IDLE;
            else if (pat_cnt == 4'hF) state_next = DONE_ST;
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      BUSY = (state == RUN);
      DONE = (state == DONE_ST);
      PASS = DONE && (FAIL_CNT == 5'd0) && (SIG == EXP_SIG);
   end

   // The counter doubles as the stimulus register; incrementing past 15 wraps
   // it to 0, which is exactly the idle stimulus required after the last capture.
   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         pat_cnt <= 4'd0;
      end else if (accept) begin
         pat_cnt <= 4'd0;
      end else if (state == RUN) begin
         if (ABORT) pat_cnt <= 4'd0;
         else       pat_cnt <= pat_cnt + 4'd1;
      end
   end

   assign {A1, A2, B1, B2} = pat_cnt;

   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         FAIL_CNT <= 5'd0;
         SIG      <= SIG_SEED;
      end else if (accept) begin
         FAIL_CNT <= 5'd0;
         SIG      <= SIG_SEED;
      end else if (capture) begin
         SIG <= misr_next;
         if ((Y_IN != exp_y) && (FAIL_CNT != 5'd31)) FAIL_CNT <= FAIL_CNT + 5'd1;
      end
   end

endmodule

// File: tb/tb_cell_bist_ctrl.sv
// Self-checking bench for cell_bist_ctrl: a behavioural OAI22 cell with
// injectable faults drives Y_IN, and expected results come from a pattern-level model.
module tb_cell_bist_ctrl;

   logic       CLK = 1'b0;
   logic       RN;
   logic       START;
   logic       ABORT;
   logic       Y_IN;
   logic       A1, A2, B1, B2;
   logic       BUSY, DONE, PASS;
   logic [4:0] FAIL_CNT;
   logic [7:0] SIG;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          mode;        // 0: good cell xor fault mask, 1: stuck-at-1, 2: stuck-at-0
   logic [15:0] mask;
   logic [3:0]  pat;

   cell_bist_ctrl dut (
      .CLK(CLK), .RN(RN), .START(START), .ABORT(ABORT), .Y_IN(Y_IN),
      .A1(A1), .A2(A2), .B1(B1), .B2(B2),
      .BUSY(BUSY), .DONE(DONE), .PASS(PASS), .FAIL_CNT(FAIL_CNT), .SIG(SIG)
   );

   always #5 CLK = ~CLK;

   function automatic logic good_y(input logic [3:0] p);
      return ~((p[3] | p[2]) & (p[1] | p[0]));
   endfunction

   function automatic logic cell_y(input int m, input logic [15:0] mk, input logic [3:0] p);
      if (m == 1) return 1'b1;
      if (m == 2) return 1'b0;
      return good_y(p) ^ mk[p];
   endfunction

   assign pat  = {A1, A2, B1, B2};
   assign Y_IN = cell_y(mode, mask, pat);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Expected result after capturing the first n patterns of the sweep.
   task automatic model(input int n, output int fails, output logic [7:0] sig);
      logic y;
      fails = 0;
      sig   = 8'hFF;
      for (int k = 0; k < n; k++) begin
         y = cell_y(mode, mask, 4'(k));
         if (y != good_y(4'(k)) && fails < 31) fails++;
         sig = ((sig << 1) & 8'hFF) ^ (sig[7] ? 8'h1D : 8'h00) ^ {7'b0, y};
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_busy"}, BUSY, 0);
      check({tag, "_done"}, DONE, 0);
      check({tag, "_pass"}, PASS, 0);
      check({tag, "_stim"}, pat, 0);
   endtask

   task automatic run_full(input int m, input logic [15:0] mk, input bit hold);
      int         e_fail;
      logic [7:0] e_sig;
      mode = m;
      mask = mk;
      model(16, e_fail, e_sig);
      @(negedge CLK);
      START = 1'b1;
      ABORT = 1'b0;
      @(negedge CLK);
      if (!hold) START = 1'b0;
      check("run_start_busy", BUSY, 1);
      check("run_start_sig", SIG, 8'hFF);
      check("run_start_stim", pat, 0);
      for (int i = 1; i <= 16; i++) begin
         @(negedge CLK);
         check("run_done_timing", DONE, (i == 16));
         if (i < 16) check("run_stim", pat, i);
      end
      check("end_busy", BUSY, 0);
      check("end_stim", pat, 0);
      check("end_fail_cnt", FAIL_CNT, e_fail);
      check("end_sig", SIG, e_sig);
      check("end_pass", PASS, (e_fail == 0) && (e_sig == 8'h5E));
   endtask

   initial begin
      int         e_fail;
      logic [7:0] e_sig;
      RN = 1'b1; START = 1'b0; ABORT = 1'b0; mode = 0; mask = '0;
      #2 RN = 1'b0;
      #1;
      check_idle("reset");
      check("reset_fail_cnt", FAIL_CNT, 0);
      check("reset_sig", SIG, 8'hFF);
      @(posedge CLK);
      #1 RN = 1'b1;

      // First edge after reset release accepts START; fault-free golden run.
      run_full(0, 16'h0, 1'b0);
      check("golden_sig", SIG, 8'h5E);
      check("golden_pass", PASS, 1);

      // ABORT outside RUN has no effect.
      @(negedge CLK) ABORT = 1'b1;
      @(negedge CLK) ABORT = 1'b0;
      check("abort_done_st", DONE, 1);

      run_full(1, 16'h0, 1'b0);
      check("stuck1_fail", FAIL_CNT, 9);
      run_full(2, 16'h0, 1'b0);
      check("stuck0_fail", FAIL_CNT, 7);

      for (int r = 0; r < 8; r++)
         run_full(0, (r % 4 == 0) ? 16'h0 : 16'($urandom), 1'b0);

      // START and ABORT together in DONE_ST: START wins.
      mode = 0; mask = '0;
      @(negedge CLK) begin START = 1'b1; ABORT = 1'b1; end
      @(negedge CLK) begin START = 1'b0; ABORT = 1'b0; end
      check("start_wins_busy", BUSY, 1);
      check("start_wins_done", DONE, 0);
      repeat (16) @(negedge CLK);
      check("start_wins_end", DONE, 1);
      check("start_wins_sig", SIG, 8'h5E);

      // Abort once pattern 5 is on the outputs; captures 0..4 only.
      mode = 0; mask = 16'($urandom);
      model(5, e_fail, e_sig);
      @(negedge CLK) START = 1'b1;
      @(negedge CLK) START = 1'b0;
      repeat (5) @(negedge CLK);
      check("abort_pat5", pat, 5);
      ABORT = 1'b1;
      @(negedge CLK) ABORT = 1'b0;
      check_idle("abort");
      check("abort_fail_cnt", FAIL_CNT, e_fail);
      check("abort_sig", SIG, e_sig);
      run_full(0, 16'h0, 1'b0);

      // Asynchronous reset while pattern 8 is applied.
      @(negedge CLK) START = 1'b1;
      @(negedge CLK) START = 1'b0;
      repeat (8) @(negedge CLK);
      check("rst_pat8", pat, 8);
      #2 RN = 1'b0;
      #1;
      check_idle("midrst");
      check("midrst_fail_cnt", FAIL_CNT, 0);
      check("midrst_sig", SIG, 8'hFF);
      @(negedge CLK) RN = 1'b1;
      repeat (20) @(negedge CLK);
      check("midrst_no_done", DONE, 0);
      check("midrst_no_busy", BUSY, 0);
      run_full(0, 16'h0, 1'b0);

      // START held high: no restart mid-run, restart at the edge after DONE.
      run_full(0, 16'h0, 1'b1);
      @(negedge CLK);
      check("hold_restart_busy", BUSY, 1);
      check("hold_restart_done", DONE, 0);
      check("hold_restart_sig", SIG, 8'hFF);
      check("hold_restart_stim", pat, 0);
      START = 1'b0;
      repeat (16) @(negedge CLK);
      check("hold_rerun_done", DONE, 1);
      check("hold_rerun_sig", SIG, 8'h5E);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
